// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and
// shift-direction constants.
package shift_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/lrShiftSFR.sv
// Left/right shift register with parallel load; load has priority over
// left, and left over right. Vacated bit positions fill with zero.
module lrShiftSFR #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic            left,
  input  logic            right,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  // register contents: load, shift by one, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {SIZE{1'b0}};
    end else if (ld) begin
      q <= d;
    end else if (left) begin
      q <= {q[SIZE-2:0], 1'b0};
    end else if (right) begin
      q <= {1'b0, q[SIZE-1:1]};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for lrShiftSFR: loads the register, issues N
// single-bit shift strobes, captures the result and hands it downstream.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int AMT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SIZE-1:0]  cmd_data,
  input  logic             cmd_dir,
  input  logic [AMT_W-1:0] cmd_amt,
  output logic             sfr_ld,
  output logic             sfr_left,
  output logic             sfr_right,
  output logic [SIZE-1:0]  sfr_d,
  input  logic [SIZE-1:0]  sfr_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SIZE-1:0]  res_data,
  output logic             busy
);

  state_t           state_r;
  state_t           state_n;
  logic             dir_r;
  logic [AMT_W-1:0] amt_r;
  logic [AMT_W-1:0] cnt_r;

  // More than SIZE shifts is indistinguishable from SIZE, so clamp there.
  function automatic logic [AMT_W-1:0] sat_amt(input logic [AMT_W-1:0] amt);
    if (amt > AMT_W'(SIZE)) begin
      return AMT_W'(SIZE);
    end else begin
      return amt;
    end
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // next-state decode
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) state_n = LOAD;
        else           state_n = IDLE;
      end
      LOAD: begin
        if (amt_r == {AMT_W{1'b0}}) state_n = CAPTURE;
        else                        state_n = SHIFT;
      end
      SHIFT: begin
        if (cnt_r == AMT_W'(1)) state_n = CAPTURE;
        else                    state_n = SHIFT;
      end
      CAPTURE: state_n = DONE;
      DONE: begin
        if (res_ready) state_n = IDLE;
        else           state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // command capture, shift counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      sfr_d    <= {SIZE{1'b0}};
      dir_r    <= DIR_LEFT;
      amt_r    <= {AMT_W{1'b0}};
      cnt_r    <= {AMT_W{1'b0}};
      res_data <= {SIZE{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            sfr_d <= cmd_data;
            dir_r <= cmd_dir;
            amt_r <= sat_amt(cmd_amt);
          end
        end
        LOAD:    cnt_r    <= amt_r;
        SHIFT:   cnt_r    <= cnt_r - AMT_W'(1);
        CAPTURE: res_data <= sfr_q;
        default: ;
      endcase
    end
  end

  // Every control output is a pure decode of registered state.
  assign cmd_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign sfr_ld    = (state_r == LOAD);
  assign sfr_left  = (state_r == SHIFT) && (dir_r == DIR_LEFT);
  assign sfr_right = (state_r == SHIFT) && (dir_r == DIR_RIGHT);
  assign res_valid = (state_r == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer driving a real lrShiftSFR: a cycle-level model
// plus directed commands with hand-computed results and latencies.
module tb_shift_sequencer;

  localparam int SIZE  = 32;
  localparam int AMT_W = 6;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SIZE-1:0]  cmd_data;
  logic             cmd_dir;
  logic [AMT_W-1:0] cmd_amt;
  logic             sfr_ld;
  logic             sfr_left;
  logic             sfr_right;
  logic [SIZE-1:0]  sfr_d;
  logic [SIZE-1:0]  sfr_q;
  logic             res_valid;
  logic             res_ready;
  logic [SIZE-1:0]  res_data;
  logic             busy;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.SIZE(SIZE), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_dir(cmd_dir), .cmd_amt(cmd_amt),
    .sfr_ld(sfr_ld), .sfr_left(sfr_left), .sfr_right(sfr_right),
    .sfr_d(sfr_d), .sfr_q(sfr_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  lrShiftSFR #(.SIZE(SIZE)) u_sfr (
    .clk(clk), .rst(rst), .ld(sfr_ld), .left(sfr_left), .right(sfr_right),
    .d(sfr_d), .q(sfr_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_p counts cycles since acceptance (1 = load cycle); the shift
  // result is plain arithmetic on the loaded value.
  logic            m_act;
  int              m_p;
  int              m_n;
  logic            m_dir;
  logic [SIZE-1:0] m_d;
  logic [SIZE-1:0] m_res;
  bit              started;

  initial begin
    m_act = 1'b0; m_p = 0; m_n = 0; m_dir = 1'b0;
    m_d = '0; m_res = '0; started = 1'b0;
    forever begin
      @(negedge clk);
      if (started) begin
        check("m_cmd_ready", 64'(cmd_ready), 64'(!m_act));
        check("m_busy",      64'(busy),      64'(m_act));
        check("m_sfr_ld",    64'(sfr_ld),    64'(m_act && m_p == 1));
        check("m_sfr_left",  64'(sfr_left),
              64'(m_act && m_p >= 2 && m_p <= 1 + m_n && !m_dir));
        check("m_sfr_right", 64'(sfr_right),
              64'(m_act && m_p >= 2 && m_p <= 1 + m_n && m_dir));
        check("m_res_valid", 64'(res_valid), 64'(m_act && m_p >= 3 + m_n));
        check("m_res_data",  64'(res_data),  64'(m_res));
        check("m_sfr_d",     64'(sfr_d),     64'(m_d));
      end
      if (rst) begin
        started = 1'b1;
        m_act = 1'b0; m_d = '0; m_res = '0; m_dir = 1'b0;
      end else if (!m_act) begin
        if (cmd_valid) begin
          m_act = 1'b1; m_p = 1;
          m_d = cmd_data; m_dir = cmd_dir;
          m_n = (int'(cmd_amt) > SIZE) ? SIZE : int'(cmd_amt);
        end
      end else begin
        if (m_p == 2 + m_n) m_res = m_dir ? (m_d >> m_n) : (m_d << m_n);
        if (m_p >= 3 + m_n && res_ready) m_act = 1'b0;
        else m_p++;
      end
    end
  end

  // present a command for one accepting edge; returns in the load cycle
  task automatic issue(input logic [SIZE-1:0] data, input logic dir, input logic [AMT_W-1:0] amt);
    cmd_valid = 1'b1; cmd_data = data; cmd_dir = dir; cmd_amt = amt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [SIZE-1:0] exp_data,
                             input int exp_lat, input int exp_l, input int exp_r,
                             input bit consume);
    int  k = 0, nld = 0, nl = 0, nr = 0;
    bit  seen = 1'b0;
    while (k < 200) begin
      if (sfr_ld)    nld++;
      if (sfr_left)  nl++;
      if (sfr_right) nr++;
      if (res_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      k++;
    end
    check({name, "_seen"},  64'(seen), 64'd1);
    check({name, "_lat"},   64'(k),    64'(exp_lat));
    check({name, "_ld"},    64'(nld),  64'd1);
    check({name, "_left"},  64'(nl),   64'(exp_l));
    check({name, "_right"}, 64'(nr),   64'(exp_r));
    check({name, "_data"},  64'(res_data), 64'(exp_data));
    if (consume) begin
      @(posedge clk); #1;
      check({name, "_idle"}, 64'(cmd_ready), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_dir = 1'b0;
    cmd_amt = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data",  64'(res_data),  64'd0);
    check("rst_sfr_d",     64'(sfr_d),     64'd0);

    issue(32'h0000_00F0, 1'b0, 6'd4);
    wait_result("left4", 32'h0000_0F00, 6, 4, 0, 1'b1);
    issue(32'h8000_0001, 1'b1, 6'd1);
    wait_result("right1", 32'h4000_0000, 3, 0, 1, 1'b1);
    issue(32'hDEAD_BEEF, 1'b0, 6'd0);
    wait_result("zero", 32'hDEAD_BEEF, 2, 0, 0, 1'b1);
    issue(32'hFFFF_FFFF, 1'b0, 6'd40);
    wait_result("satl", 32'h0000_0000, 34, 32, 0, 1'b1);
    issue(32'hFFFF_FFFF, 1'b1, 6'd63);
    wait_result("satr", 32'h0000_0000, 34, 0, 32, 1'b1);

    // backpressure with ignored commands arriving while busy
    res_ready = 1'b0;
    issue(32'h1234_5678, 1'b1, 6'd3);
    wait_result("bp", 32'h0246_8ACF, 5, 0, 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = ~cmd_valid; cmd_data = $urandom; cmd_amt = 6'd1;
      @(posedge clk); #1;
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_data",  64'(res_data),  64'h0246_8ACF);
      check("bp_ready", 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 64'(cmd_ready), 64'd1);
    check("bp_release_valid", 64'(res_valid), 64'd0);

    // reset while shifting abandons the command
    issue(32'hF0F0_0000, 1'b1, 6'd10);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_busy",  64'(busy),      64'd0);
    check("mid_rst_strb",  64'({sfr_ld, sfr_left, sfr_right}), 64'd0);
    check("mid_rst_sfr_d", 64'(sfr_d),     64'd0);
    check("mid_rst_res",   64'(res_data),  64'd0);
    for (int i = 0; i < 15; i++) begin
      check("mid_rst_novalid", 64'(res_valid), 64'd0);
      @(posedge clk); #1;
    end
    issue(32'h0000_0003, 1'b0, 6'd2);
    wait_result("after_rst", 32'h0000_000C, 4, 2, 0, 1'b1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
